mem_addr_unit: RTL and testbench

- 16-bit memory address register (MAR) that drives the memory block's address input.
- Loads its value byte-wise from the 8-bit main bus, increments or decrements it, and can drive either byte back onto the main bus.
- Contains a small indirect-fetch sequencer. It reads a little-endian 16-bit pointer from memory at the current address, using the memory's combinational read data, and loads that pointer into the MAR.
- Sits directly upstream of the memory: addr_out feeds the memory address, and mem_data comes from the memory read output.

---
 rtl/mem_addr_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_addr_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_addr_unit.sv
// mem_addr_unit -- memory address register (MAR) with indirect pointer fetch.
//
// Holds a WIDTH_ADDR-bit address that drives the memory address input.
// The address is loaded byte-wise from the main bus, stepped up or down,
// and either byte can be driven back onto the main bus. A small sequencer
// reads a little-endian pointer from memory at the current address and
// loads it into the MAR.
//
// WIDTH_ADDR must equal 2*WIDTH (the MAR is exactly two bus bytes).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   main_in    main bus data in
//   load_lo    load MAR low byte from main_in
//   load_hi    load MAR high byte from main_in
//   inc, dec   step MAR up / down (modulo 2^WIDTH_ADDR)
//   assert_lo  drive MAR low byte onto the main bus
//   assert_hi  drive MAR high byte onto the main bus
//   main_out   byte driven toward the main bus
//   main_en    main bus drive enable
//   ind_start  begin indirect pointer fetch
//   mem_data   combinational memory read data at addr_out
//   addr_out   memory address
//   busy       sequencer active
//   done       one-cycle pulse when the fetched pointer is loaded
//   wrap       one-cycle flag: last inc/dec wrapped around
module mem_addr_unit #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      main_in,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  assert_lo,
  input  logic                  assert_hi,
  output logic [WIDTH-1:0]      main_out,
  output logic                  main_en,
  input  logic                  ind_start,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [WIDTH_ADDR-1:0] addr_out,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_t;

  localparam logic [WIDTH_ADDR-1:0] ADDR_ONE = WIDTH_ADDR'(1);

  state_t                  state, state_nxt;
  logic [WIDTH_ADDR-1:0]   mar, mar_nxt;
  logic [WIDTH_ADDR-1:0]   ptr, ptr_nxt;
  logic [WIDTH-1:0]        tmp_lo, tmp_lo_nxt;
  logic                    done_nxt;
  logic                    wrap_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mar    <= '0;
      ptr    <= '0;
      tmp_lo <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mar    <= mar_nxt;
      ptr    <= ptr_nxt;
      tmp_lo <= tmp_lo_nxt;
      done   <= done_nxt;
      wrap   <= wrap_nxt;
    end
  end

  // Next-state logic: sequencer steps and IDLE-time MAR operations.
  always_comb begin
    state_nxt  = state;
    mar_nxt    = mar;
    ptr_nxt    = ptr;
    tmp_lo_nxt = tmp_lo;
    done_nxt   = 1'b0;
    wrap_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ind_start) begin
          // Fetch start wins; any load/inc/dec this cycle is dropped.
          ptr_nxt   = mar;
          state_nxt = RD_LO;
        end else if (load_lo || load_hi) begin
          if (load_lo) begin
            mar_nxt[WIDTH-1:0] = main_in;
          end else begin
            mar_nxt[WIDTH-1:0] = mar[WIDTH-1:0];
          end
          if (load_hi) begin
            mar_nxt[WIDTH_ADDR-1:WIDTH] = main_in;
          end else begin
            mar_nxt[WIDTH_ADDR-1:WIDTH] = mar[WIDTH_ADDR-1:WIDTH];
          end
        end else if (inc && dec) begin
          mar_nxt = mar;
        end else if (inc) begin
          mar_nxt  = mar + ADDR_ONE;
          wrap_nxt = (mar == '1);
        end else if (dec) begin
          mar_nxt  = mar - ADDR_ONE;
          wrap_nxt = (mar == '0);
        end else begin
          mar_nxt = mar;
        end
      end
      RD_LO: begin
        tmp_lo_nxt = mem_data;
        state_nxt  = RD_HI;
      end
      RD_HI: begin
        mar_nxt   = {mem_data, tmp_lo};
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory address: MAR when idle, pointer bytes while fetching.
  always_comb begin
    addr_out = mar;
    case (state)
      IDLE:    addr_out = mar;
      RD_LO:   addr_out = ptr;
      RD_HI:   addr_out = ptr + ADDR_ONE;
      default: addr_out = mar;
    endcase
  end

  // Bus drive: exactly one assert in IDLE enables the bus; otherwise quiet.
  always_comb begin
    main_en  = 1'b0;
    main_out = '0;
    if ((state == IDLE) && (assert_lo ^ assert_hi)) begin
      main_en = 1'b1;
      if (assert_lo) begin
        main_out = mar[WIDTH-1:0];
      end else begin
        main_out = mar[WIDTH_ADDR-1:WIDTH];
      end
    end else begin
      main_en  = 1'b0;
      main_out = '0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_addr_unit.sv
// Scoreboard bench for mem_addr_unit: the driver pushes the expected
// bus response (checked mid-cycle, pre-edge) and the expected post-edge
// address/status; a monitor process pops and compares every cycle.
module tb_mem_addr_unit;

  logic        clk;
  logic        reset_n;
  logic [7:0]  main_in;
  logic        load_lo, load_hi, inc, dec, assert_lo, assert_hi, ind_start;
  logic [7:0]  main_out;
  logic        main_en;
  logic [7:0]  mem_data;
  logic [15:0] addr_out;
  logic        busy, done, wrap;

  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic        wrap;
    logic        en;
    logic [7:0]  out;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    failures;

  mem_addr_unit #(.WIDTH_ADDR(16), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .main_in(main_in),
    .load_lo(load_lo), .load_hi(load_hi), .inc(inc), .dec(dec),
    .assert_lo(assert_lo), .assert_hi(assert_hi),
    .main_out(main_out), .main_en(main_en),
    .ind_start(ind_start), .mem_data(mem_data), .addr_out(addr_out),
    .busy(busy), .done(done), .wrap(wrap)
  );

  assign mem_data = mem[addr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
    end
  endtask

  // Monitor: bus outputs sampled mid-cycle, registered state after the edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q[0];
        nm = name_q[0];
        chk(nm, "main_en", {15'd0, main_en}, {15'd0, e.en});
        chk(nm, "main_out", {8'd0, main_out}, {8'd0, e.out});
        @(posedge clk);
        #1;
        chk(nm, "addr_out", addr_out, e.addr);
        chk(nm, "busy", {15'd0, busy}, {15'd0, e.busy});
        chk(nm, "done", {15'd0, done}, {15'd0, e.done});
        chk(nm, "wrap", {15'd0, wrap}, {15'd0, e.wrap});
        void'(exp_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  task automatic set_in(input logic ll, input logic lh, input logic i, input logic d,
                        input logic al, input logic ah, input logic st, input logic [7:0] din);
    load_lo = ll; load_hi = lh; inc = i; dec = d;
    assert_lo = al; assert_hi = ah; ind_start = st; main_in = din;
  endtask

  // Push the expected response for the current inputs and advance one cycle.
  task automatic step(input string nm, input logic [15:0] a, input logic b, input logic dn,
                      input logic w, input logic en, input logic [7:0] o);
    exp_t e;
    e.addr = a; e.busy = b; e.done = dn; e.wrap = w; e.en = en; e.out = o;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    mem[16'h2000] = 8'hCD;
    mem[16'h2001] = 8'hAB;
    mem[16'hFFFF] = 8'h78;
    mem[16'h0000] = 8'h56;
    mem[16'h5678] = 8'h11;
    mem[16'h5679] = 8'h22;
    @(posedge clk);
    #2;
    //                 name        addr      busy done wrap en  out
    step("reset",      16'h0000, 0, 0, 0, 0, 8'h00);
    reset_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h34); step("load_lo",   16'h0034, 0, 0, 0, 0, 8'h00);
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h12); step("load_hi",   16'h1234, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 1, 0, 8'h00); step("assert_hi", 16'h1234, 0, 0, 0, 1, 8'h12);
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00); step("assert_lo", 16'h1234, 0, 0, 0, 1, 8'h34);
    set_in(1, 0, 0, 0, 1, 0, 0, 8'h99); step("assert_ld", 16'h1299, 0, 0, 0, 1, 8'h34);
    set_in(1, 1, 0, 0, 0, 0, 0, 8'hFF); step("load_both", 16'hFFFF, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 1, 0, 0, 0, 0, 8'h00); step("inc_wrap",  16'h0000, 0, 0, 1, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00); step("wrap_clr",  16'h0000, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 1, 0, 0, 0, 8'h00); step("dec_wrap",  16'hFFFF, 0, 0, 1, 0, 8'h00);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h05); step("ld_lo05",   16'hFF05, 0, 0, 0, 0, 8'h00);
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h00); step("ld_hi00",   16'h0005, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 1, 1, 0, 0, 0, 8'h00); step("inc_dec",   16'h0005, 0, 0, 0, 0, 8'h00);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'hFF); step("ld_00ff",   16'h00FF, 0, 0, 0, 0, 8'h00);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h10); step("ld_wins",   16'h0010, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 1, 1, 0, 8'h00); step("both_ast",  16'h0010, 0, 0, 0, 0, 8'h00);
    // Indirect fetch from 2000.
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h20); step("ld_2020",   16'h2020, 0, 0, 0, 0, 8'h00);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00); step("ld_2000",   16'h2000, 0, 0, 0, 0, 8'h00);
    set_in(1, 0, 0, 0, 0, 0, 1, 8'h55); step("ind_e0",    16'h2000, 1, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00); step("ind_e1",    16'h2001, 1, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00); step("ind_e2",    16'hABCD, 0, 1, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00); step("ind_post",  16'hABCD, 0, 0, 0, 0, 8'h00);
    // Indirect fetch from FFFF; pointer high byte read from 0000.
    set_in(1, 1, 0, 0, 0, 0, 0, 8'hFF); step("ld_ffff",   16'hFFFF, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 1, 8'h00); step("ff_e0",     16'hFFFF, 1, 0, 0, 0, 8'h00);
    set_in(1, 0, 1, 0, 0, 0, 0, 8'h11); step("ff_e1",     16'h0000, 1, 0, 0, 0, 8'h00);
    set_in(0, 1, 1, 0, 0, 1, 1, 8'h22); step("ff_e2",     16'h5678, 0, 1, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00); step("ff_post",   16'h5678, 0, 0, 0, 0, 8'h00);
    // Reset while in RD_HI.
    set_in(0, 0, 0, 0, 0, 0, 1, 8'h00); step("rs_e0",     16'h5678, 1, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00); step("rs_e1",     16'h5679, 1, 0, 0, 0, 8'h00);
    reset_n = 1'b0;
    step("rs_mid",    16'h0000, 0, 0, 0, 0, 8'h00);
    reset_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h42); step("rs_load",   16'h0042, 0, 0, 0, 0, 8'h00);
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00); step("rs_ast",    16'h0042, 0, 0, 0, 1, 8'h42);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
